// File: rtl/pulse_train_pkg.sv
// Shared types and defaults for the pulse train generator.
// Optional abort port: define PULSE_TRAIN_ABORT_EN.
package pulse_train_pkg;

  localparam int PT_WIDTH_W = 4;
  localparam int PT_COUNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LEAD = 2'd1,
    HIGH = 2'd2,
    GAP  = 2'd3
  } pt_state_e;

endpackage

// File: rtl/pulse_train_phase_cnt.sv
// Loadable down-counter timing one high or low phase.
// Holds at zero; o_zero marks the last cycle of a phase.
module pulse_train_phase_cnt
  import pulse_train_pkg::*;
#(
  parameter int W = PT_WIDTH_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic         o_zero
);

  logic [W-1:0] r_cnt;

  // load a phase length, otherwise count down and stop at zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/pulse_train_generator.sv
// Drives a programmable train of high pulses separated by low gaps.
// Optional abort port: define PULSE_TRAIN_ABORT_EN.
module pulse_train_generator
  import pulse_train_pkg::*;
#(
  parameter int WIDTH_W = PT_WIDTH_W,
  parameter int COUNT_W = PT_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH_W-1:0] width,
  input  logic [WIDTH_W-1:0] gap,
  input  logic [COUNT_W-1:0] count,
`ifdef PULSE_TRAIN_ABORT_EN
  input  logic               abort,
`endif
  output logic               pulse_out,
  output logic               busy,
  output logic               done
);

  pt_state_e          r_state;
  pt_state_e          w_next;
  logic [WIDTH_W-1:0] r_width;
  logic [WIDTH_W-1:0] r_gap;
  logic [COUNT_W-1:0] r_remain;
  logic               w_latch;
  logic               w_dec;
  logic               w_load;
  logic [WIDTH_W-1:0] w_load_val;
  logic               w_zero;
  logic               w_abort;

  // zero-length phases run as one cycle so every pulse stays flanked by lows
  function automatic logic [WIDTH_W-1:0] phase_len(
    input logic [WIDTH_W-1:0] v
  );
    return (v == '0) ? '0 : v - 1'b1;
  endfunction

`ifdef PULSE_TRAIN_ABORT_EN
  assign w_abort = abort && (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  pulse_train_phase_cnt #(
    .W(WIDTH_W)
  ) u_phase (
    .clk   (clk),
    .rst   (rst),
    .i_load(w_load),
    .i_val (w_load_val),
    .o_zero(w_zero)
  );

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next state plus phase/pulse counter control
  always_comb begin
    w_next     = r_state;
    w_latch    = 1'b0;
    w_dec      = 1'b0;
    w_load     = 1'b0;
    w_load_val = '0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_next  = LEAD;
          w_latch = 1'b1;
        end
      end
      LEAD: begin
        if (r_remain == '0) begin
          w_next = IDLE;
        end else begin
          w_next     = HIGH;
          w_load     = 1'b1;
          w_load_val = phase_len(r_width);
        end
      end
      HIGH: begin
        if (w_zero) begin
          w_next     = GAP;
          w_dec      = 1'b1;
          w_load     = 1'b1;
          w_load_val = phase_len(r_gap);
        end
      end
      GAP: begin
        if (w_zero) begin
          if (r_remain != '0) begin
            w_next     = HIGH;
            w_load     = 1'b1;
            w_load_val = phase_len(r_width);
          end else begin
            w_next = IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
    if (w_abort) begin
      w_next = IDLE;
      w_dec  = 1'b0;
    end
  end

  // train parameters captured at launch; pulse budget spent per high phase
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_width  <= '0;
      r_gap    <= '0;
      r_remain <= '0;
    end else if (w_latch) begin
      r_width  <= width;
      r_gap    <= gap;
      r_remain <= count;
    end else if (w_dec) begin
      r_remain <= r_remain - 1'b1;
    end
  end

  // registered outputs follow the state being entered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      pulse_out <= (w_next == HIGH);
      busy      <= (w_next != IDLE);
      done      <= (r_state != IDLE) && (w_next == IDLE) && !w_abort;
    end
  end

endmodule

// File: tb/tb_pulse_train_generator.sv
// Directed self-checking bench for pulse_train_generator.
// Define PULSE_TRAIN_ABORT_EN to also exercise abort.
module tb_pulse_train_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [3:0] width = '0;
  logic [3:0] gap = '0;
  logic [7:0] count = '0;
`ifdef PULSE_TRAIN_ABORT_EN
  logic       abort = 1'b0;
`endif
  logic       pulse_out;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pulse_train_generator #(
    .WIDTH_W(4),
    .COUNT_W(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .width    (width),
    .gap      (gap),
    .count    (count),
`ifdef PULSE_TRAIN_ABORT_EN
    .abort    (abort),
`endif
    .pulse_out(pulse_out),
    .busy     (busy),
    .done     (done)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int w, input int g, input int c);
    width = w[3:0];
    gap   = g[3:0];
    count = c[7:0];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // checks the waveform cycle by cycle; poke re-strobes start with other
  // parameters at that cycle index, which must change nothing
  task automatic expect_train(input string tag, input string exp, input int poke);
    for (int i = 0; i < exp.len(); i++) begin
      check({tag, " pulse"}, int'(pulse_out), (exp[i] == "1") ? 1 : 0);
      check({tag, " busy"}, int'(busy), 1);
      check({tag, " done_lo"}, int'(done), 0);
      if (i == poke) begin
        start = 1'b1;
        width = 4'd7;
        gap   = 4'd7;
        count = 8'd9;
      end
      tick();
      start = 1'b0;
    end
    check({tag, " done"}, int'(done), 1);
    check({tag, " idle"}, int'(busy), 0);
    check({tag, " end_lo"}, int'(pulse_out), 0);
  endtask

  initial begin
    int rises;
    int cyc;
    logic prev;

    #2;
    check("rst pulse", int'(pulse_out), 0);
    check("rst busy", int'(busy), 0);
    check("rst done", int'(done), 0);
    tick();
    rst = 1'b0;
    tick();
    check("idle busy", int'(busy), 0);

    launch(1, 1, 2);
    expect_train("w1g1c2", "01010", -1);
    tick();
    check("done strobe 1cyc", int'(done), 0);

    launch(3, 2, 1);
    expect_train("w3g2c1", "011100", -1);
    tick();

    launch(0, 0, 3);
    expect_train("w0g0c3", "0101010", -1);
    tick();

    launch(5, 5, 0);
    expect_train("c0", "0", -1);
    tick();

    launch(2, 1, 1);
    expect_train("busy_start", "0110", 1);

    // start in the done cycle is accepted
    launch(1, 2, 1);
    expect_train("done_start", "0100", -1);
    tick();

    // longest train: 255 single-cycle pulses
    launch(1, 1, 255);
    rises = 0;
    cyc   = 0;
    prev  = 1'b0;
    while (!done && cyc < 2000) begin
      if (pulse_out && !prev) rises++;
      prev = pulse_out;
      tick();
      cyc++;
    end
    check("max timeout", int'(done), 1);
    check("max pulses", rises, 255);
    check("max cycles", cyc, 511);
    tick();

    // async reset mid-train
    launch(4, 1, 3);
    tick();
    tick();
    check("pre_rst pulse", int'(pulse_out), 1);
    rst = 1'b1;
    #1;
    check("async rst pulse", int'(pulse_out), 0);
    check("async rst busy", int'(busy), 0);
    check("async rst done", int'(done), 0);
    tick();
    rst = 1'b0;
    tick();
    check("post rst done", int'(done), 0);
    check("post rst busy", int'(busy), 0);

`ifdef PULSE_TRAIN_ABORT_EN
    launch(4, 1, 3);
    for (int i = 0; i < 7; i++) tick();
    check("abort pre pulse", int'(pulse_out), 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort pulse", int'(pulse_out), 0);
    check("abort busy", int'(busy), 0);
    check("abort done", int'(done), 0);
    tick();
    check("abort no done", int'(done), 0);
    abort = 1'b1;
    launch(1, 1, 1);
    abort = 1'b0;
    check("idle abort start", int'(busy), 1);
    expect_train("idle_abort", "010", -1);
    tick();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
